timer_seconds: RTL

Memory-mapped countdown timer peripheral on the CPU's peripheral bus, sitting between the store/load decode in the top level and the program's wait-for-timeout loop. Software writes a duration in seconds; the block counts it down from the 10 MHz system clock and raises a sticky done flag that the CPU polls. A status word exposes the remaining seconds for the display path. `SIMULATION` shortens the one-second tick so benches finish quickly.

---
 rtl/timer_pkg.sv | 11 +
 rtl/timer_seconds_tick_prescaler.sv | 20 ++
 rtl/timer_seconds.sv | 64 ++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register bit positions and tick-length helper for timer_seconds.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;
  localparam int ABORT_BIT = 31;
  localparam int SECS_MSB = 15;
  localparam int DONE_BIT = 0;
  localparam int BUSY_BIT = 1;
  function automatic int tick_len(input bit simulation, input int clk_hz, input int sim_tick);
    return simulation ? sim_tick : clk_hz;
  endfunction
endpackage

// File: rtl/timer_seconds_tick_prescaler.sv
// tick_prescaler: down-counter that pulses tick on its terminal count and reloads TICK-1.
module tick_prescaler #(
  parameter int TICK = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(TICK);
  localparam logic [W-1:0] RELOAD = W'(TICK - 1);
  logic [W-1:0] cnt;
  assign tick = en && !load && cnt == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (load || tick) cnt <= RELOAD;
    else if (en) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/timer_seconds.sv
// timer_seconds: memory-mapped seconds countdown timer with sticky done flag and remaining-seconds readback.
module timer_seconds
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter bit SIMULATION = 1'b0,
  parameter int SIM_TICK = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_we,
  input  logic [31:0] ctrl_wdata,
  input  logic        done_clr,
  output logic [31:0] done_rdata,
  output logic [31:0] remain_rdata
);
  localparam int TICK = tick_len(SIMULATION, CLK_HZ, SIM_TICK);
  timer_state_t state, state_nx;
  logic [15:0] remaining, remaining_nx;
  logic busy, done, tick;
  wire abort = ctrl_wdata[ABORT_BIT];
  wire [15:0] secs = ctrl_wdata[SECS_MSB:0];
  wire start = ctrl_we && !abort && secs != '0;
  tick_prescaler #(.TICK(TICK)) u_pre (
    .clk(clk),
    .reset(reset),
    .load(start),
    .en(state == RUN),
    .tick(tick)
  );
  // a write always takes priority; the last second lands in DONE instead of reloading
  always_comb begin
    state_nx = state;
    remaining_nx = remaining;
    if (ctrl_we) begin
      state_nx = abort ? IDLE : (secs == '0 ? DONE : RUN);
      remaining_nx = abort ? 16'd0 : secs;
    end else if (state == RUN && tick) begin
      state_nx = remaining > 16'd1 ? RUN : DONE;
      remaining_nx = remaining > 16'd1 ? remaining - 16'd1 : 16'd0;
    end else if (state == DONE && done_clr) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      remaining <= remaining_nx;
      busy <= state_nx == RUN;
      done <= state_nx == DONE;
    end
  end
  always_comb begin
    done_rdata = '0;
    done_rdata[DONE_BIT] = done;
    done_rdata[BUSY_BIT] = busy;
  end
  assign remain_rdata = {16'd0, remaining};
endmodule
